// File: rtl/lfsr_prbs_gen.sv
// Fibonacci LFSR pattern source with a valid/ready output.
// Supports free-run and counted-burst modes, runtime seed load, pattern-match pulse and a transfer counter.
module lfsr_prbs_gen #(
    parameter int                 WIDTH = 16,
    parameter logic [WIDTH-1:0]   TAPS  = WIDTH'(16'hD008),
    parameter logic [WIDTH-1:0]   SEED  = {{(WIDTH-1){1'b0}}, 1'b1},
    parameter int                 LEN_W = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                mode,
    input  logic                enable,
    input  logic                start,
    input  logic [LEN_W-1:0]    burst_len,
    input  logic                load,
    input  logic [WIDTH-1:0]    seed_in,
    input  logic                out_ready,
    output logic                out_valid,
    output logic [WIDTH-1:0]    data_out,
    input  logic [WIDTH-1:0]    match_val,
    output logic                match_hit,
    output logic                busy,
    output logic                done,
    output logic [31:0]         xfer_count
);

    // state | meaning
    // IDLE  | free-run operation, or waiting for a burst start
    // RUN   | burst in progress, remain_q words still to transfer
    // DONE  | one-cycle end-of-burst indication
    typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_t;

    fsm_t               fsm_q, fsm_d;
    logic [WIDTH-1:0]   state_q;
    logic [WIDTH-1:0]   state_next;
    logic [WIDTH-1:0]   tapped;
    logic               fb;
    logic [LEN_W-1:0]   remain_q, remain_d;
    logic               valid_d;
    logic               xfer;

    // An all-zero tap field shifts in a 1 so the register can never lock at zero.
    assign tapped     = state_q & TAPS;
    assign fb         = (^tapped) | ~(|tapped);
    assign state_next = {state_q[WIDTH-2:0], fb};

    assign xfer      = out_valid & out_ready;
    assign data_out  = state_q;
    assign busy      = (fsm_q == RUN);
    assign done      = (fsm_q == DONE);

    always_comb begin
        fsm_d    = fsm_q;
        remain_d = remain_q;
        valid_d  = 1'b0;
        case (fsm_q)
            IDLE: begin
                if (mode) begin
                    if (start) begin
                        remain_d = burst_len;
                        if (burst_len != '0) begin
                            fsm_d   = RUN;
                            valid_d = 1'b1;
                        end else begin
                            fsm_d = DONE;
                        end
                    end
                end else begin
                    valid_d = enable;
                end
            end
            RUN: begin
                valid_d = 1'b1;
                if (xfer) begin
                    remain_d = remain_q - 1'b1;
                    if (remain_q == LEN_W'(1)) begin
                        fsm_d   = DONE;
                        valid_d = 1'b0;
                    end
                end
            end
            DONE: begin
                fsm_d   = IDLE;
                valid_d = ~mode & enable;
            end
            default: fsm_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= SEED;
            fsm_q      <= IDLE;
            remain_q   <= '0;
            out_valid  <= 1'b0;
            match_hit  <= 1'b0;
            xfer_count <= '0;
        end else begin
            fsm_q     <= fsm_d;
            remain_q  <= remain_d;
            out_valid <= valid_d;
            match_hit <= xfer && (state_q == match_val);
            if (xfer) begin
                xfer_count <= xfer_count + 32'd1;
            end
            // A coincident transfer is still counted above, using the pre-load word.
            if (load) begin
                state_q <= (seed_in == '0) ? SEED : seed_in;
            end else if (xfer) begin
                state_q <= state_next;
            end
        end
    end

endmodule

// File: tb/tb_lfsr_prbs_gen.sv
// Scoreboard bench for lfsr_prbs_gen: stimulus pushes predicted words, a negedge monitor pops and compares.
`timescale 1ns/1ps
module tb_lfsr_prbs_gen;
    localparam int              W        = 16;
    localparam int              LW       = 16;
    localparam logic [W-1:0]    TAPS_REF = 16'hD008;
    localparam logic [W-1:0]    SEED_REF = 16'h0001;

    logic           clk = 1'b0;
    logic           rst;
    logic           mode, enable, start, load, out_ready;
    logic [LW-1:0]  burst_len;
    logic [W-1:0]   seed_in, match_val;
    logic           out_valid, match_hit, busy, done;
    logic [W-1:0]   data_out;
    logic [31:0]    xfer_count;

    always #5 clk = ~clk;

    lfsr_prbs_gen dut (
        .clk(clk), .rst(rst), .mode(mode), .enable(enable), .start(start),
        .burst_len(burst_len), .load(load), .seed_in(seed_in), .out_ready(out_ready),
        .out_valid(out_valid), .data_out(data_out), .match_val(match_val),
        .match_hit(match_hit), .busy(busy), .done(done), .xfer_count(xfer_count)
    );

    int             checks = 0;
    int             failures = 0;
    logic [W-1:0]   exp_q[$];
    logic [W-1:0]   m_state;
    int             tot;
    int             done_count = 0;
    int             act_hits = 0;
    logic           exp_hit = 1'b0;
    logic [W-1:0]   mon_word;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference step: count set tap bits; odd parity or no tapped bit set shifts in a 1.
    function automatic logic [W-1:0] ref_next(input logic [W-1:0] s);
        int n_set = 0;
        for (int i = 0; i < W; i++) if (TAPS_REF[i] && s[i]) n_set++;
        return {s[W-2:0], ((n_set == 0) || (n_set % 2 == 1))};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_words(input int n);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(m_state);
            m_state = ref_next(m_state);
            tot++;
        end
    endtask

    task automatic drain(input int max_cycles, input bit rnd);
        int c = 0;
        while (exp_q.size() > 0 && c < max_cycles) begin
            out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            tick();
            c++;
        end
        out_ready = 1'b0;
        check("drain_timeout", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic stop_free_run();
        out_ready = 1'b0;
        enable = 1'b0;
        tick();
        tick();
    endtask

    always @(negedge clk) begin
        if (rst) begin
            exp_hit = 1'b0;
        end else begin
            check("match_hit", 64'(match_hit), 64'(exp_hit));
            if (match_hit) act_hits++;
            if (done) begin
                done_count++;
                check("busy_in_done", 64'(busy), 64'd0);
            end
            exp_hit = 1'b0;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_xfer: got word %0h expected no transfer at %0t", data_out, $time);
                end else begin
                    mon_word = exp_q.pop_front();
                    check("data_out", 64'(data_out), 64'(mon_word));
                    exp_hit = (mon_word == match_val);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int dc0, len, kind, n;
        logic [W-1:0] sv, tmp;

        rst = 1'b1; mode = 1'b0; enable = 1'b0; start = 1'b0; load = 1'b0;
        burst_len = '0; seed_in = '0; out_ready = 1'b0; match_val = 16'h007F;
        m_state = SEED_REF; tot = 0;

        enable = 1'b1;
        tick(); tick();
        check("rst_data", 64'(data_out), 64'(SEED_REF));
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_hit", 64'(match_hit), 64'd0);
        check("rst_xfer", 64'(xfer_count), 64'd0);

        // Free-run, 1-cycle valid latency, backpressure at word 000F, match on 007F.
        rst = 1'b0;
        check("valid_latency0", 64'(out_valid), 64'd0);
        tick();
        check("valid_latency1", 64'(out_valid), 64'd1);
        push_words(3);
        drain(50, 1'b0);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("hold_data", 64'(data_out), 64'h000F);
            check("hold_valid", 64'(out_valid), 64'd1);
        end
        push_words(5);
        drain(50, 1'b0);
        tick();
        check("xfer8", 64'(xfer_count), 64'd8);
        check("match_once", 64'(act_hits), 64'd1);
        stop_free_run();
        check("fr_stop_valid", 64'(out_valid), 64'd0);

        // Burst of 5.
        mode = 1'b1; burst_len = 16'd5; start = 1'b1;
        dc0 = done_count;
        push_words(5);
        tick();
        start = 1'b0;
        check("burst_busy", 64'(busy), 64'd1);
        check("burst_valid", 64'(out_valid), 64'd1);
        drain(100, 1'b1);
        tick(); tick();
        check("burst_done_once", 64'(done_count), 64'(dc0 + 1));
        check("burst_end_valid", 64'(out_valid), 64'd0);
        check("burst_end_busy", 64'(busy), 64'd0);
        check("burst_xfer", 64'(xfer_count), 64'(tot));

        // Zero-length burst: done pulse, no words even with ready high.
        burst_len = '0; start = 1'b1; out_ready = 1'b1;
        dc0 = done_count;
        tick();
        start = 1'b0;
        check("len0_done", 64'(done), 64'd1);
        tick(); tick();
        out_ready = 1'b0;
        check("len0_done_once", 64'(done_count), 64'(dc0 + 1));
        check("len0_xfer", 64'(xfer_count), 64'(tot));
        mode = 1'b0;

        // Seed load 8000 -> 8000, 0001.
        load = 1'b1; seed_in = 16'h8000;
        tick();
        load = 1'b0;
        m_state = 16'h8000;
        check("seed_8000", 64'(data_out), 64'h8000);
        enable = 1'b1;
        push_words(2);
        drain(50, 1'b0);
        stop_free_run();

        // Seed 0 substitutes SEED.
        load = 1'b1; seed_in = '0;
        tick();
        load = 1'b0;
        m_state = SEED_REF;
        check("seed_zero", 64'(data_out), 64'(SEED_REF));

        // Load coincident with a transfer.
        enable = 1'b1;
        tick();
        push_words(1);
        sv = W'($urandom_range(1, 65535));
        seed_in = sv; load = 1'b1; out_ready = 1'b1;
        tick();
        load = 1'b0; out_ready = 1'b0;
        m_state = sv;
        check("load_xfer_count", 64'(xfer_count), 64'(tot));
        check("load_xfer_data", 64'(data_out), 64'(sv));
        push_words(3);
        drain(50, 1'b0);
        stop_free_run();

        // Randomized mix of free-run chunks, bursts and seed loads.
        for (int it = 0; it < 16; it++) begin
            tmp = m_state;
            repeat ($urandom_range(0, 6)) tmp = ref_next(tmp);
            match_val = ($urandom_range(0, 1) == 1) ? tmp : W'($urandom);
            kind = $urandom_range(0, 2);
            if (kind == 0) begin
                n = $urandom_range(1, 20);
                enable = 1'b1;
                push_words(n);
                drain(400, 1'b1);
                stop_free_run();
            end else if (kind == 1) begin
                len = $urandom_range(0, 12);
                mode = 1'b1; burst_len = LW'(len); start = 1'b1;
                dc0 = done_count;
                push_words(len);
                tick();
                start = 1'b0;
                if (len > 0) check("rnd_busy", 64'(busy), 64'd1);
                drain(400, 1'b1);
                n = 0;
                while (done_count == dc0 && n < 20) begin
                    tick();
                    n++;
                end
                tick();
                check("rnd_done_once", 64'(done_count), 64'(dc0 + 1));
                check("rnd_idle_valid", 64'(out_valid), 64'd0);
                mode = 1'b0;
            end else begin
                sv = ($urandom_range(0, 3) == 0) ? '0 : W'($urandom);
                load = 1'b1; seed_in = sv;
                tick();
                load = 1'b0;
                m_state = (sv == '0) ? SEED_REF : sv;
                check("rnd_seed", 64'(data_out), 64'(m_state));
            end
            check("rnd_xfer_count", 64'(xfer_count), 64'(tot));
        end

        // Async reset mid-burst after 2 of 10 words.
        mode = 1'b1; burst_len = 16'd10; start = 1'b1;
        push_words(10);
        tick();
        start = 1'b0;
        n = 0;
        while (exp_q.size() > 8 && n < 50) begin
            out_ready = 1'b1;
            tick();
            n++;
        end
        out_ready = 1'b0;
        check("mid_two_words", 64'(exp_q.size()), 64'd8);
        check("mid_busy", 64'(busy), 64'd1);
        #2;
        rst = 1'b1;
        #1;
        check("arst_data", 64'(data_out), 64'(SEED_REF));
        check("arst_busy", 64'(busy), 64'd0);
        check("arst_valid", 64'(out_valid), 64'd0);
        check("arst_done", 64'(done), 64'd0);
        check("arst_xfer", 64'(xfer_count), 64'd0);
        exp_q.delete();
        tot = 0;
        m_state = SEED_REF;
        dc0 = done_count;
        repeat (3) tick();
        rst = 1'b0;
        mode = 1'b0; enable = 1'b0;
        tick(); tick();
        check("arst_no_done", 64'(done_count), 64'(dc0));
        check("arst_idle_busy", 64'(busy), 64'd0);
        check("arst_post_xfer", 64'(xfer_count), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
